// File: rtl/hdr_pkg.sv
// Shared constants for the HDR image generator: exposure buffer layout,
// RGB565 field positions and the camera packer state encoding.
package hdr_pkg;

    localparam int unsigned FRAME_WORDS    = 19200;
    localparam logic [24:0] BUF_STRIDE     = 25'h25800;
    localparam logic [24:0] ADDR_STEP      = 25'd8;
    localparam int unsigned NUM_BUFS       = 6;
    localparam int unsigned PIX_PER_WORD   = 16;
    localparam int unsigned BYTES_PER_WORD = 2 * PIX_PER_WORD;

    // RGB565 fields inside one 16-bit pixel
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_B_MSB = 4;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_G_MSB = 10;
    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_R_MSB = 15;

    typedef enum logic [2:0] {
        StSync,
        StCapture,
        StFlush,
        StDone,
        StWait
    } cap_state_e;

    function automatic logic [24:0] buf_base(input logic [2:0] idx);
        return 25'(idx) * BUF_STRIDE;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO between the byte packer and the RAM write port.
// A push while full is accepted only if a pop happens in the same cycle.
module word_fifo2
    import hdr_pkg::*;
#(
    parameter int unsigned Width = BYTES_PER_WORD * 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/camera_packer.sv
// Packs RGB565 camera bytes into 256-bit words and writes them to the exposure buffers.
// Define FRAME_CHECK_EN to add the frame_err output (word count / partial word check).
module camera_packer
    import hdr_pkg::*;
#(
    parameter int unsigned FrameWords = FRAME_WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cam_vsync,
    input  logic         cam_href,
    input  logic [7:0]   cam_data,
    input  logic         cam_byte_valid,
    input  logic         ram_busy,
    output logic [255:0] camera_data,
    output logic         camera_wr_req,
    output logic [24:0]  wr_address,
    output logic         frame_done,
    output logic [2:0]   last_frame,
`ifdef FRAME_CHECK_EN
    output logic         frame_err,
`endif
    output logic         overflow
);

    localparam int unsigned CntW = $clog2(FrameWords + 1);

    cap_state_e      state_q, state_d;
    logic            vsync_q;
    logic [4:0]      byte_cnt_q;
    logic [255:0]    pack_q;
    logic            word_ready_q;
    logic [CntW-1:0] word_cnt_q;
    logic [24:0]     addr_q;
    logic [2:0]      last_frame_q;
    logic            overflow_q;

    logic vsync_rise, vsync_fall;
    logic in_capture, start_capture;
    logic byte_take;
    logic under_limit, push_req, push_ok, drop;
    logic issue;
    logic fifo_full, fifo_empty;
    logic [255:0] fifo_head;

    assign vsync_rise    = cam_vsync && !vsync_q;
    assign vsync_fall    = !cam_vsync && vsync_q;
    assign in_capture    = (state_q == StCapture);
    assign start_capture = ((state_q == StSync) || (state_q == StWait)) && vsync_fall;
    assign byte_take     = in_capture && cam_byte_valid && cam_href && !vsync_rise;

    assign issue       = !fifo_empty && !ram_busy;
    assign under_limit = (word_cnt_q < CntW'(FrameWords));
    // Words past the frame limit vanish silently; only a full FIFO counts as overflow.
    assign push_req    = word_ready_q && under_limit;
    assign push_ok     = push_req && (!fifo_full || issue);
    assign drop        = push_req && !push_ok;

    word_fifo2 #(
        .Width (256)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (pack_q),
        .pop       (issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        unique case (state_q)
            StSync, StWait: begin
                if (vsync_fall) state_d = StCapture;
            end
            StCapture: begin
                if (vsync_rise) state_d = StFlush;
            end
            StFlush: begin
                if (fifo_empty && !word_ready_q) state_d = StDone;
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StWait;
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSync;
            vsync_q      <= 1'b0;
            byte_cnt_q   <= 5'd0;
            pack_q       <= '0;
            word_ready_q <= 1'b0;
            word_cnt_q   <= '0;
            addr_q       <= 25'd0;
            last_frame_q <= 3'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= cam_vsync;
            word_ready_q <= byte_take && (byte_cnt_q == 5'd31);

            if (start_capture || (in_capture && vsync_rise)) begin
                byte_cnt_q <= 5'd0;
            end else if (byte_take) begin
                byte_cnt_q <= byte_cnt_q + 5'd1;
            end

            // The completed word stays intact for the push cycle: byte 0 of the next
            // word lands only at the end of that cycle.
            if (byte_take) begin
                pack_q[{byte_cnt_q, 3'b000} +: 8] <= cam_data;
            end

            if (start_capture) begin
                word_cnt_q <= '0;
            end else if (push_ok) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end

            if (start_capture) begin
                addr_q <= buf_base(last_frame_q);
            end else if (issue) begin
                addr_q <= addr_q + ADDR_STEP;
            end

            if (state_q == StDone) begin
                last_frame_q <= (last_frame_q == 3'(NUM_BUFS - 1)) ? 3'd0 : last_frame_q + 3'd1;
            end

            if (start_capture) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    logic partial_q;
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (start_capture) begin
                partial_q <= 1'b0;
            end else if (in_capture && vsync_rise && (byte_cnt_q != 5'd0)) begin
                partial_q <= 1'b1;
            end
            if (state_q == StDone) begin
                frame_err_q <= (word_cnt_q != CntW'(FrameWords)) || partial_q;
            end
        end
    end

    assign frame_err = frame_err_q;
`endif

    assign camera_data   = fifo_head;
    assign camera_wr_req = issue;
    assign wr_address    = addr_q;
    assign last_frame    = last_frame_q;
    assign overflow      = overflow_q;

endmodule
